// File: rtl/board_key_pkg.sv
// board_key_pkg: shared scan FSM encoding and event-word field helpers for board_key_ctrl.
package board_key_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  function automatic int unsigned idx_w(input int unsigned n_keys);
    return (n_keys > 1) ? $clog2(n_keys) : 1;
  endfunction

  function automatic int unsigned evt_press_bit(input int unsigned data_width);
    return data_width - 1;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// key_event_fifo: show-ahead event FIFO with sticky overflow on dropped pushes.
module key_event_fifo #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned FIFO_DEPTH_BITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic                  clr_overflow,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  empty,
  output logic                  overflow
);

  localparam int unsigned DEPTH = 2 ** FIFO_DEPTH_BITS;
  localparam logic [FIFO_DEPTH_BITS:0] FULL_CNT = {1'b1, {FIFO_DEPTH_BITS{1'b0}}};

  logic [DATA_WIDTH-1:0]      mem [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr;
  logic [FIFO_DEPTH_BITS-1:0] rd_ptr;
  logic [FIFO_DEPTH_BITS:0]   count;
  logic                       full;
  logic                       do_pop;
  logic                       do_push;
  logic                       drop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push while full is accepted.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign data    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/board_key_ctrl.sv
// board_key_ctrl: debounces active-low board keys and queues key events into a show-ahead FIFO.
// Build option BOARD_KEY_CTRL_RELEASE_EN: queue release events as well as press events.
module board_key_ctrl
  import board_key_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned KEY_WIDTH       = 6,
  parameter int unsigned DEBOUNCE_BITS   = 16,
  parameter int unsigned FIFO_DEPTH_BITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [KEY_WIDTH-1:0]  key_n,
  input  logic                  rd_en,
  input  logic                  clr_overflow,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  empty,
  output logic                  overflow,
  output logic [KEY_WIDTH-1:0]  key_state
);

  localparam int unsigned IDX_W     = idx_w(KEY_WIDTH);
  localparam int unsigned EVT_PRESS = evt_press_bit(DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KEY_WIDTH - 1);
`ifdef BOARD_KEY_CTRL_RELEASE_EN
  localparam bit RELEASE_EN = 1'b1;
`else
  localparam bit RELEASE_EN = 1'b0;
`endif

  logic [DEBOUNCE_BITS-1:0] tick_cnt;
  logic                     tick;
  logic [KEY_WIDTH-1:0]     lvl;
  logic [KEY_WIDTH-1:0]     smp;
  logic [KEY_WIDTH-1:0]     chg;
  logic [KEY_WIDTH-1:0]     evt_mask;
  logic [KEY_WIDTH-1:0]     pend;
  logic [KEY_WIDTH-1:0]     clr_mask;
  logic [IDX_W-1:0]         idx;
  scan_state_t              state;
  logic                     push;
  logic                     push_level;
  logic [DATA_WIDTH-1:0]    push_data;

  assign tick     = (tick_cnt == '1);
  assign lvl      = ~key_n;
  // Two consecutive agreeing samples that differ from the debounced level.
  assign chg      = ~(smp ^ lvl) & (smp ^ key_state);
  assign evt_mask = RELEASE_EN ? chg : (chg & lvl);

  always_comb begin
    push       = 1'b0;
    push_level = 1'b0;
    clr_mask   = '0;
    for (int unsigned k = 0; k < KEY_WIDTH; k++) begin
      if (state == SCAN && idx == IDX_W'(k) && pend[k]) begin
        push        = 1'b1;
        push_level  = key_state[k];
        clr_mask[k] = 1'b1;
      end
    end
    push_data            = '0;
    push_data[EVT_PRESS] = push_level;
    push_data[IDX_W-1:0] = idx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt  <= '0;
      smp       <= '0;
      key_state <= '0;
      pend      <= '0;
      idx       <= '0;
      state     <= IDLE;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
      if (tick) begin
        smp       <= lvl;
        key_state <= key_state ^ chg;
      end
      pend <= (pend & ~clr_mask) | (tick ? evt_mask : '0);
      case (state)
        IDLE: begin
          if (pend != '0) begin
            state <= SCAN;
            idx   <= '0;
          end
        end
        SCAN: begin
          if (idx == LAST_IDX) state <= IDLE;
          else idx <= idx + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  key_event_fifo #(
    .DATA_WIDTH     (DATA_WIDTH),
    .FIFO_DEPTH_BITS(FIFO_DEPTH_BITS)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_data   (push_data),
    .pop         (rd_en),
    .clr_overflow(clr_overflow),
    .data        (data),
    .empty       (empty),
    .overflow    (overflow)
  );

endmodule

// File: tb/tb_board_key_ctrl.sv
// tb_board_key_ctrl: scenario tasks plus randomized run against a queue-based event model.
module tb_board_key_ctrl;

  localparam int unsigned DW = 8, KW = 6, DB = 4, FDB = 2;
  localparam int DEPTH  = 4;
  localparam int PERIOD = 16;
`ifdef BOARD_KEY_CTRL_RELEASE_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rd_en = 1'b0;
  logic          clr_overflow = 1'b0;
  logic [KW-1:0] key_n = '1;
  logic [KW-1:0] key_state;
  logic [DW-1:0] data;
  logic          empty;
  logic          overflow;

  board_key_ctrl #(
    .DATA_WIDTH     (DW),
    .KEY_WIDTH      (KW),
    .DEBOUNCE_BITS  (DB),
    .FIFO_DEPTH_BITS(FDB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_n       (key_n),
    .rd_en       (rd_en),
    .clr_overflow(clr_overflow),
    .data        (data),
    .empty       (empty),
    .overflow    (overflow),
    .key_state   (key_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            at;
    logic [DW-1:0] w;
  } sched_t;

  int            cyc;
  logic [KW-1:0] m_smp;
  logic [KW-1:0] m_ks;
  logic [DW-1:0] mq[$];
  sched_t        sq[$];
  bit            m_ovf;
  int            n_chk = 0;
  int            n_pass = 0;

  function automatic logic [DW-1:0] evt_word(input bit press, input int k);
    logic [DW-1:0] w;
    w = '0;
    w[DW-1] = press;
    w[2:0] = k[2:0];
    return w;
  endfunction

  // One clock: sample inputs, advance the model by the behavioural rules, return #1 after the edge.
  task automatic step();
    logic r, rd, clr;
    logic [KW-1:0] kn;
    bit dropped, lvl;
    sched_t s;
    r = reset; rd = rd_en; clr = clr_overflow; kn = key_n;
    @(posedge clk);
    #1;
    if (r) begin
      cyc = 0; m_smp = '0; m_ks = '0; m_ovf = 1'b0;
      mq.delete(); sq.delete();
    end else begin
      dropped = 1'b0;
      cyc++;
      if (rd && mq.size() > 0) void'(mq.pop_front());
      if (sq.size() > 0 && sq[0].at == cyc) begin
        if (mq.size() < DEPTH) mq.push_back(sq[0].w);
        else dropped = 1'b1;
        void'(sq.pop_front());
      end
      if (dropped) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (cyc % PERIOD == 0) begin
        for (int k = 0; k < KW; k++) begin
          lvl = ~kn[k];
          if (m_smp[k] == lvl && m_ks[k] != lvl) begin
            m_ks[k] = lvl;
            if (REL_EN || lvl) begin
              s.at = cyc + 2 + k;
              s.w  = evt_word(lvl, k);
              sq.push_back(s);
            end
          end
          m_smp[k] = lvl;
        end
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    reset = 1'b1; rd_en = 1'b0; clr_overflow = 1'b0; key_n = '1;
    run(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty); else n_pass++;
    n_chk++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else n_pass++;
    n_chk++; if (key_state !== 6'b0) $display("FAIL reset_key_state: got %b want 000000", key_state); else n_pass++;
    n_chk++; if (data !== 8'h00) $display("FAIL reset_data: got %h want 00", data); else n_pass++;
  endtask

  task automatic test_press();
    do_reset();
    key_n = 6'b111011;
    for (int i = 0; i < 40; i++) begin
      step();
      n_chk++;
      if (empty !== (mq.size() == 0)) $display("FAIL press_empty@%0d: got %b want %b", cyc, empty, mq.size() == 0);
      else n_pass++;
    end
    n_chk++; if (key_state !== 6'b000100) $display("FAIL press_key_state: got %b want 000100", key_state); else n_pass++;
    n_chk++; if (data !== 8'h82) $display("FAIL press_data: got %h want 82", data); else n_pass++;
    rd_en = 1'b1; step(); rd_en = 1'b0;
    n_chk++; if (empty !== 1'b1) $display("FAIL press_pop_empty: got %b want 1", empty); else n_pass++;
  endtask

  task automatic test_glitch();
    do_reset();
    for (int i = 0; i < PERIOD && cyc % PERIOD != 14; i++) step();
    key_n[2] = 1'b0;
    run(3);
    key_n[2] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      n_chk++; if (empty !== 1'b1) $display("FAIL glitch_empty@%0d: got %b want 1", cyc, empty); else n_pass++;
    end
    n_chk++; if (key_state !== 6'b0) $display("FAIL glitch_key_state: got %b want 000000", key_state); else n_pass++;
  endtask

  task automatic test_multi();
    logic [DW-1:0] exp_w [3];
    exp_w = '{8'h80, 8'h83, 8'h85};
    do_reset();
    key_n = ~6'b101001;
    for (int i = 0; i < 40; i++) begin
      step();
      n_chk++;
      if (empty !== (mq.size() == 0)) $display("FAIL multi_empty@%0d: got %b want %b", cyc, empty, mq.size() == 0);
      else n_pass++;
    end
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (data !== exp_w[i]) $display("FAIL multi_data%0d: got %h want %h", i, data, exp_w[i]); else n_pass++;
      rd_en = 1'b1; step(); rd_en = 1'b0;
    end
    n_chk++; if (empty !== 1'b1) $display("FAIL multi_drained: got %b want 1", empty); else n_pass++;
  endtask

  task automatic test_overflow();
    int n_got, n_exp;
    bit ovf_exp;
`ifdef BOARD_KEY_CTRL_RELEASE_EN
    n_exp = 4; ovf_exp = 1'b1;
`else
    n_exp = 3; ovf_exp = 1'b0;
`endif
    do_reset();
    for (int t = 0; t < 6; t++) begin
      key_n[1] = (t % 2 == 1);
      run(40);
    end
    n_chk++; if (overflow !== ovf_exp) $display("FAIL ovf_set: got %b want %b", overflow, ovf_exp); else n_pass++;
    clr_overflow = 1'b1; step(); clr_overflow = 1'b0;
    n_chk++; if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", overflow); else n_pass++;
    n_got = 0;
    for (int i = 0; i < 8 && !empty; i++) begin
      n_chk++;
      if (mq.size() == 0 || data !== mq[0]) $display("FAIL ovf_data%0d: got %h want %h", i, data, (mq.size() > 0) ? mq[0] : 8'hxx);
      else n_pass++;
      rd_en = 1'b1; step(); rd_en = 1'b0;
      n_got++;
    end
    n_chk++; if (n_got != n_exp) $display("FAIL ovf_held: got %0d want %0d", n_got, n_exp); else n_pass++;
  endtask

  task automatic test_full_pushpop();
    logic [DW-1:0] exp_w [4];
    int n_got;
    exp_w = '{8'h81, 8'h82, 8'h84, 8'h85};
    do_reset();
    key_n = ~6'b010111;
    run(40);
    key_n[5] = 1'b0;
    for (int i = 0; i < 48; i++) begin
      rd_en = (sq.size() > 0 && sq[0].at == cyc + 1);
      step();
      n_chk++; if (overflow !== 1'b0) $display("FAIL full_pp_ovf@%0d: got %b want 0", cyc, overflow); else n_pass++;
    end
    rd_en = 1'b0;
    n_got = 0;
    for (int i = 0; i < 8 && !empty; i++) begin
      n_chk++;
      if (i < 4 && data !== exp_w[i]) $display("FAIL full_pp_data%0d: got %h want %h", i, data, exp_w[i]);
      else n_pass++;
      rd_en = 1'b1; step(); rd_en = 1'b0;
      n_got++;
    end
    n_chk++; if (n_got != 4) $display("FAIL full_pp_count: got %0d want 4", n_got); else n_pass++;
  endtask

  task automatic test_release_cfg();
    logic [DW-1:0] exp_w [2];
    int n_got, n_exp;
    exp_w = '{8'h84, 8'h04};
`ifdef BOARD_KEY_CTRL_RELEASE_EN
    n_exp = 2;
`else
    n_exp = 1;
`endif
    do_reset();
    key_n[4] = 1'b0; run(40);
    key_n[4] = 1'b1; run(40);
    n_chk++; if (key_state !== 6'b0) $display("FAIL rel_key_state: got %b want 000000", key_state); else n_pass++;
    n_got = 0;
    for (int i = 0; i < 4 && !empty; i++) begin
      n_chk++;
      if (i < 2 && data !== exp_w[i]) $display("FAIL rel_data%0d: got %h want %h", i, data, exp_w[i]);
      else n_pass++;
      rd_en = 1'b1; step(); rd_en = 1'b0;
      n_got++;
    end
    n_chk++; if (n_got != n_exp) $display("FAIL rel_count: got %0d want %0d", n_got, n_exp); else n_pass++;
  endtask

  task automatic test_reset_mid_scan();
    bit in_scan;
    do_reset();
    key_n = '0;
    in_scan = 1'b0;
    for (int i = 0; i < 48 && !in_scan; i++) begin
      step();
      in_scan = (sq.size() > 0 && mq.size() > 0);
    end
    n_chk++; if (empty !== 1'b0) $display("FAIL rst_scan_pre_empty: got %b want 0", empty); else n_pass++;
    reset = 1'b1; step(); reset = 1'b0;
    n_chk++; if (empty !== 1'b1) $display("FAIL rst_scan_empty: got %b want 1", empty); else n_pass++;
    n_chk++; if (key_state !== 6'b0) $display("FAIL rst_scan_key_state: got %b want 000000", key_state); else n_pass++;
    run(40);
    n_chk++; if (key_state !== m_ks) $display("FAIL rst_scan_relearn: got %b want %b", key_state, m_ks); else n_pass++;
  endtask

  task automatic test_random();
    int b;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(11) == 0) begin
        b = $urandom_range(KW - 1);
        key_n[b] = ~key_n[b];
      end
      rd_en        = ($urandom_range(3) == 0);
      clr_overflow = ($urandom_range(23) == 0);
      reset        = ($urandom_range(499) == 0);
      step();
      n_chk++; if (key_state !== m_ks) $display("FAIL rnd_key_state@%0d: got %b want %b", i, key_state, m_ks); else n_pass++;
      n_chk++; if (empty !== (mq.size() == 0)) $display("FAIL rnd_empty@%0d: got %b want %b", i, empty, mq.size() == 0); else n_pass++;
      n_chk++; if (overflow !== m_ovf) $display("FAIL rnd_overflow@%0d: got %b want %b", i, overflow, m_ovf); else n_pass++;
      if (mq.size() > 0) begin
        n_chk++; if (data !== mq[0]) $display("FAIL rnd_data@%0d: got %h want %h", i, data, mq[0]); else n_pass++;
      end
    end
    reset = 1'b0; rd_en = 1'b0; clr_overflow = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_multi();
    test_overflow();
    test_full_pushpop();
    test_release_cfg();
    test_reset_mid_scan();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
